// File: rtl/mdu_ctrl.sv
// Multiply/divide controller for the MIPS EX stage: owns HI/LO, runs one fixed-latency
// mult/multu/div/divu at a time and writes mthi/mtlo directly.
module mdu_ctrl #(
   parameter int unsigned MUL_CYCLES = 5,
   parameter int unsigned DIV_CYCLES = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        rejected
);

   localparam int unsigned MaxCycles = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

   localparam logic [CntW-1:0] MulLoad = CntW'(MUL_CYCLES - 1);
   localparam logic [CntW-1:0] DivLoad = CntW'(DIV_CYCLES - 1);

   localparam logic [2:0] OpNop   = 3'd0;
   localparam logic [2:0] OpMult  = 3'd1;
   localparam logic [2:0] OpMultu = 3'd2;
   localparam logic [2:0] OpDiv   = 3'd3;
   localparam logic [2:0] OpMthi  = 3'd5;
   localparam logic [2:0] OpMtlo  = 3'd6;
   localparam logic [2:0] OpRsvd  = 3'd7;

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2:0]      op_q, op_d;
   logic [31:0]     a_q, a_d;
   logic [31:0]     b_q, b_d;
   logic [31:0]     hi_q, hi_d;
   logic [31:0]     lo_q, lo_d;
   logic            rejected_q, rejected_d;

   logic        op_valid;
   logic        is_mul;
   logic        sgn_mul;
   logic        sgn_div;
   logic [63:0] a_ext, b_ext, prod;
   logic        a_neg, b_neg, div_zero;
   logic [31:0] a_mag, b_mag, divisor, quo_u, rem_u, quo, rem;

   assign op_valid = (op != OpNop) && (op != OpRsvd);

   // Datapath works only on latched operands, so inputs may change freely while running.
   always_comb begin
      is_mul   = (op_q == OpMult) || (op_q == OpMultu);
      sgn_mul  = (op_q == OpMult);
      sgn_div  = (op_q == OpDiv);
      a_ext    = {{32{sgn_mul & a_q[31]}}, a_q};
      b_ext    = {{32{sgn_mul & b_q[31]}}, b_q};
      prod     = a_ext * b_ext;
      a_neg    = sgn_div & a_q[31];
      b_neg    = sgn_div & b_q[31];
      a_mag    = a_neg ? (32'd0 - a_q) : a_q;
      b_mag    = b_neg ? (32'd0 - b_q) : b_q;
      div_zero = (b_q == 32'd0);
      // Divisor forced to 1 on zero so the divider never sees x; the result is discarded.
      divisor  = div_zero ? 32'd1 : b_mag;
      quo_u    = a_mag / divisor;
      rem_u    = a_mag % divisor;
      quo      = (a_neg ^ b_neg) ? (32'd0 - quo_u) : quo_u;
      rem      = a_neg ? (32'd0 - rem_u) : rem_u;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         op_q       <= '0;
         a_q        <= '0;
         b_q        <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
         rejected_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         op_q       <= op_d;
         a_q        <= a_d;
         b_q        <= b_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         rejected_q <= rejected_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      op_d       = op_q;
      a_d        = a_q;
      b_d        = b_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      rejected_d = 1'b0;
      case (state_q)
         StIdle: begin
            if (start && op_valid) begin
               if (op == OpMthi) begin
                  hi_d = a;
               end else if (op == OpMtlo) begin
                  lo_d = a;
               end else begin
                  state_d = StRun;
                  op_d    = op;
                  a_d     = a;
                  b_d     = b;
                  cnt_d   = ((op == OpMult) || (op == OpMultu)) ? MulLoad : DivLoad;
               end
            end
         end
         StRun: begin
            // Still in RUN on the commit edge, so a start there is dropped too.
            rejected_d = start && op_valid;
            if (cnt_q == '0) begin
               state_d = StIdle;
               if (is_mul) begin
                  {hi_d, lo_d} = prod;
               end else if (!div_zero) begin
                  hi_d = rem;
                  lo_d = quo;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      busy     = (state_q == StRun);
      hi       = hi_q;
      lo       = lo_q;
      rejected = rejected_q;
   end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: expected commits are queued at issue time and checked by a
// monitor when busy falls; rejected pulses are counted by the monitor.
module tb_mdu_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a, b;
   logic        busy;
   logic [31:0] hi, lo;
   logic        rejected;

   typedef struct {
      string       name;
      int          cyc;
      logic [31:0] hi;
      logic [31:0] lo;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   rej_cnt = 0;
   bit   mon_en = 1'b0;
   logic busy_prev = 1'b0;
   int   run_len = 0;

   mdu_ctrl #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .op       (op),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .hi       (hi),
      .lo       (lo),
      .rejected (rejected)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb);
      start = 1'b1;
      op    = o;
      a     = va;
      b     = vb;
      tick();
      start = 1'b0;
      op    = 3'd0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 60 && busy; i++) tick();
      check("idle_timeout", {31'd0, busy}, 32'd0);
   endtask

   task automatic push(input string name, input int cyc, input logic [31:0] h,
                       input logic [31:0] l);
      exp_t e;
      e.name = name;
      e.cyc  = cyc;
      e.hi   = h;
      e.lo   = l;
      sb.push_back(e);
   endtask

   // Monitor: a falling busy marks a commit (or an abort); compare against the queue head.
   always @(negedge clk) begin
      if (rejected) rej_cnt++;
      if (busy && !busy_prev) run_len = 1;
      else if (busy) run_len++;
      if (mon_en && !busy && busy_prev) begin
         if (sb.size() == 0) begin
            check("unexpected_commit", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check({e.name, "_busy_cycles"}, run_len, e.cyc);
            check({e.name, "_hi"}, hi, e.hi);
            check({e.name, "_lo"}, lo, e.lo);
         end
      end
      busy_prev = busy;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b0;
      start = 1'b0;
      op    = 3'd0;
      a     = '0;
      b     = '0;
      tick();
      tick();
      reset = 1'b1;

      // 1: random activity, then reset held for two edges with a competing start
      for (int i = 0; i < 12; i++) begin
         start = 1'($urandom_range(0, 1));
         op    = 3'($urandom_range(0, 7));
         a     = $urandom();
         b     = $urandom();
         tick();
      end
      start = 1'b1;
      op    = 3'd5;
      a     = 32'hDEAD_BEEF;
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      start = 1'b0;
      op    = 3'd0;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_hi", hi, 32'd0);
      check("rst_lo", lo, 32'd0);
      check("rst_rejected", {31'd0, rejected}, 32'd0);
      tick();
      mon_en = 1'b1;

      // 2: mult / multu latency and results
      push("mult", 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
      issue(3'd1, 32'hFFFF_FFFE, 32'd3);
      a = 32'h1234_5678;
      b = 32'h0;
      wait_idle();
      push("multu", 5, 32'd2, 32'hFFFF_FFFA);
      issue(3'd2, 32'hFFFF_FFFE, 32'd3);
      wait_idle();

      // 3: division signs and overflow
      push("div_neg", 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      issue(3'd3, 32'hFFFF_FFF9, 32'd2);
      wait_idle();
      push("divu", 10, 32'd1, 32'd3);
      issue(3'd4, 32'd7, 32'd2);
      wait_idle();
      push("div_ovf", 10, 32'd0, 32'h8000_0000);
      issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_idle();

      // 4: divide by zero keeps preloaded HI/LO
      issue(3'd5, 32'h11, 32'd0);
      check("mthi", hi, 32'h11);
      issue(3'd6, 32'h22, 32'd0);
      check("mtlo", lo, 32'h22);
      check("mthi_busy", {31'd0, busy}, 32'd0);
      push("divu_zero", 10, 32'h11, 32'h22);
      issue(3'd4, 32'd5, 32'd0);
      wait_idle();

      // 5: collisions on the 2nd busy cycle and on the commit edge; reserved op ignored
      tick();
      rej_cnt = 0;
      push("coll_mult", 5, 32'd0, 32'd42);
      issue(3'd1, 32'd6, 32'd7);
      tick();
      start = 1'b1; op = 3'd6; a = 32'h99;
      tick();
      start = 1'b1; op = 3'd7; a = 32'h77;
      tick();
      start = 1'b0; op = 3'd0;
      tick();
      start = 1'b1; op = 3'd6; a = 32'h99;
      tick();
      tick();
      start = 1'b0; op = 3'd0;
      check("mtlo_after_busy", lo, 32'h99);
      tick();
      tick();
      check("rejected_pulses", rej_cnt, 32'd2);

      // 6: reset on the 4th busy cycle aborts the divide
      issue(3'd5, 32'h55, 32'd0);
      push("rst_mid", 4, 32'd0, 32'd0);
      issue(3'd3, 32'd100, 32'd7);
      tick();
      tick();
      tick();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_hi", hi, 32'd0);
      check("abort_lo", lo, 32'd0);
      repeat (15) tick();
      check("no_late_busy", {31'd0, busy}, 32'd0);
      check("no_late_hi", hi, 32'd0);
      check("no_late_lo", lo, 32'd0);
      check("sb_drained", sb.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
